// File: rtl/mpi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : mpi_slave_if
//  Description : 1801VM1-style asynchronous bus bundle (SYNC/DIN/DOUT/WTBT/
//                RPLY plus address and data lines). The master drives the
//                cycle-control, address and write-data lines. A responder
//                drives RPLY and the read-data lines.
//  Ports       : bus_addr, bus_wdata (master->slave, 16 bit)
//                bus_rdata          (slave->master, 16 bit, zero when idle)
//                SYNC, DIN, DOUT, WTBT (master->slave, cycle control)
//                RPLY               (slave->master, reply pulse)
//  Revision    : 1.0  initial release
// ============================================================================
interface mpi_slave_if;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        SYNC;
    logic        DIN;
    logic        DOUT;
    logic        WTBT;
    logic        RPLY;

    modport master (
        output bus_addr, bus_wdata, SYNC, DIN, DOUT, WTBT,
        input  bus_rdata, RPLY
    );

    modport slave (
        input  bus_addr, bus_wdata, SYNC, DIN, DOUT, WTBT,
        output bus_rdata, RPLY
    );
endinterface
`default_nettype wire

// File: rtl/mpi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : mpi_slave
//  Description : Bus responder for the 1801VM1 SYNC/DIN/DOUT/WTBT/RPLY bus.
//                It decodes a 2^(AW+1)-byte window at BASE and runs one word
//                or byte access on a synchronous RAM port. It then answers
//                with a one-ce-cycle RPLY pulse. Out-of-window cycles are
//                ignored, so they get no sel and no reply.
//  Ports       : clk, reset_n (sync, active low), ce (clock enable)
//                bus      : mpi_slave_if.slave bus bundle
//                sel      : responder owns the current cycle
//                mem_addr : RAM word address (AW bits)
//                mem_rd   : RAM read strobe
//                mem_we   : RAM byte-lane write enables {hi,lo}
//                mem_wdata: RAM write data
//                mem_rdata: RAM read data, valid one clk after mem_rd
//  Revision    : 1.0  initial release
// ============================================================================
module mpi_slave #(
    parameter logic [15:0] BASE        = 16'o100000,
    parameter int          AW          = 10,
    parameter int          WAIT_STATES = 0
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          ce,
    mpi_slave_if.slave         bus,
    output logic               sel,
    output logic [AW-1:0]      mem_addr,
    output logic               mem_rd,
    output logic [1:0]         mem_we,
    output logic [15:0]        mem_wdata,
    input  wire logic [15:0]   mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_ACCESS  = 3'd2,
        S_CAPTURE = 3'd3,
        S_REPLY   = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    // BASE is aligned to the window size, so only the bits above the window
    // need comparing.
    localparam logic [15:0] c_win_mask = 16'(~((32'd1 << (AW + 1)) - 32'd1));
    localparam logic [3:0]  c_wait     = 4'(WAIT_STATES);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_addr;
    logic            r_dir;      // 1 = write
    logic            r_byte;
    logic            r_odd;
    logic [15:0]     r_wdata;
    logic [15:0]     r_rdata;
    logic            r_sel;

    logic            w_cyc;
    logic            w_in_win;
    logic            w_latch;
    logic            w_to_idle;
    logic            w_mem_rd;
    logic [1:0]      w_mem_we;

    assign w_cyc    = bus.SYNC & (bus.DIN ^ bus.DOUT);
    assign w_in_win = (bus.bus_addr & c_win_mask) == (BASE & c_win_mask);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else if (ce)
            r_state <= w_next;
    end

    // Next state and strobes
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_mem_rd  = 1'b0;
        w_mem_we  = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (w_cyc) begin
                    if (w_in_win) begin
                        w_latch = 1'b1;
                        w_next  = (c_wait == 4'd0) ? S_ACCESS : S_WAIT;
                    end else begin
                        // Park until SYNC drops so the foreign cycle is not
                        // re-decoded while it is still active.
                        w_next = S_RELEASE;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.SYNC)
                    w_next = S_IDLE;
                else if (r_cnt <= 4'd1)
                    w_next = S_ACCESS;
            end
            S_ACCESS: begin
                w_next = bus.SYNC ? S_CAPTURE : S_IDLE;
                if (!r_dir)
                    w_mem_rd = 1'b1;
                else if (!r_byte)
                    w_mem_we = 2'b11;
                else
                    w_mem_we = r_odd ? 2'b10 : 2'b01;
            end
            S_CAPTURE: w_next = bus.SYNC ? S_REPLY : S_IDLE;
            S_REPLY:   w_next = bus.SYNC ? S_RELEASE : S_IDLE;
            S_RELEASE: if (!bus.SYNC) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    assign w_to_idle = (w_next == S_IDLE) && (r_state != S_IDLE);

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_dir   <= 1'b0;
            r_byte  <= 1'b0;
            r_odd   <= 1'b0;
            r_wdata <= 16'd0;
            r_rdata <= 16'd0;
            r_sel   <= 1'b0;
        end else if (ce) begin
            if (w_latch) begin
                r_addr  <= bus.bus_addr[AW:1];
                r_dir   <= bus.DOUT;
                r_byte  <= bus.WTBT;
                r_odd   <= bus.bus_addr[0];
                r_wdata <= bus.bus_wdata;
                r_cnt   <= c_wait;
                r_sel   <= 1'b1;
            end
            if (r_state == S_WAIT && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            // Full word is returned; the master picks the byte it wants.
            if (r_state == S_CAPTURE && bus.SYNC && !r_dir)
                r_rdata <= mem_rdata;
            // Any return to IDLE (normal end or abort) releases the bus.
            if (w_to_idle) begin
                r_rdata <= 16'd0;
                r_sel   <= 1'b0;
            end
        end
    end

    assign bus.RPLY      = (r_state == S_REPLY);
    assign bus.bus_rdata = r_rdata;
    assign sel           = r_sel;
    assign mem_addr      = r_addr;
    assign mem_rd        = w_mem_rd;
    assign mem_we        = w_mem_we;
    assign mem_wdata     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mpi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mpi_slave
//  Description : Directed self-checking bench for mpi_slave. Instance u0 has
//                WAIT_STATES=0 and instance u4 has WAIT_STATES=4. Each has a
//                read-only RAM model whose data is a fixed pattern of the
//                address.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mpi_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, ce;
    logic        sync, din, dout, wtbt, tgt;
    logic [15:0] addr, wdata;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rply, n_rd, n_we, n_sel;

    mpi_slave_if b0();
    mpi_slave_if b4();

    assign b0.bus_addr  = addr;
    assign b0.bus_wdata = wdata;
    assign b0.SYNC      = sync & ~tgt;
    assign b0.DIN       = din;
    assign b0.DOUT      = dout;
    assign b0.WTBT      = wtbt;
    assign b4.bus_addr  = addr;
    assign b4.bus_wdata = wdata;
    assign b4.SYNC      = sync & tgt;
    assign b4.DIN       = din;
    assign b4.DOUT      = dout;
    assign b4.WTBT      = wtbt;

    logic        sel0, sel4, mrd0, mrd4;
    logic [9:0]  maddr0, maddr4;
    logic [1:0]  mwe0, mwe4;
    logic [15:0] mwd0, mwd4, mrdata0, mrdata4;

    mpi_slave #(.BASE(16'o100000), .AW(10), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .bus(b0), .sel(sel0),
        .mem_addr(maddr0), .mem_rd(mrd0), .mem_we(mwe0),
        .mem_wdata(mwd0), .mem_rdata(mrdata0)
    );

    mpi_slave #(.BASE(16'o100000), .AW(10), .WAIT_STATES(4)) u4 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .bus(b4), .sel(sel4),
        .mem_addr(maddr4), .mem_rd(mrd4), .mem_we(mwe4),
        .mem_wdata(mwd4), .mem_rdata(mrdata4)
    );

    // RAM models: word 0 = 16'o123456, otherwise addr ^ 16'hA5C3
    always @(posedge clk) begin
        if (mrd0) mrdata0 <= (maddr0 == 10'd0) ? 16'o123456 : ({6'd0, maddr0} ^ 16'hA5C3);
        if (mrd4) mrdata4 <= (maddr4 == 10'd0) ? 16'o123456 : ({6'd0, maddr4} ^ 16'hA5C3);
    end

    // Observation of the currently targeted responder
    logic        rply, sel, mrd;
    logic [1:0]  mwe;
    logic [9:0]  maddr;
    logic [15:0] rdata, mwd;
    assign rply  = tgt ? b4.RPLY      : b0.RPLY;
    assign rdata = tgt ? b4.bus_rdata : b0.bus_rdata;
    assign sel   = tgt ? sel4   : sel0;
    assign mrd   = tgt ? mrd4   : mrd0;
    assign mwe   = tgt ? mwe4   : mwe0;
    assign maddr = tgt ? maddr4 : maddr0;
    assign mwd   = tgt ? mwd4   : mwd0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (rply)        n_rply++;
        if (mrd)         n_rd++;
        if (mwe != 2'b0) n_we++;
        if (sel)         n_sel++;
    endtask

    task automatic start(input logic t, input logic [15:0] a, input logic rd,
                         input logic w, input logic [15:0] d);
        tgt = t; addr = a; din = rd; dout = ~rd; wtbt = w; wdata = d; sync = 1'b1;
        n_rply = 0; n_rd = 0; n_we = 0; n_sel = 0;
    endtask

    task automatic endc;
        sync = 1'b0; din = 1'b0; dout = 1'b0; wtbt = 1'b0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; ce = 1'b1; sync = 1'b0; din = 1'b0; dout = 1'b0;
        wtbt = 1'b0; tgt = 1'b0; addr = 16'd0; wdata = 16'd0;
        n_rply = 0; n_rd = 0; n_we = 0; n_sel = 0;
        tick; tick;
        chk("rst_ctl",   16'({rply, sel, mrd, mwe}), 16'h0);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_maddr", 16'(maddr), 16'h0);
        chk("rst_mwd",   mwd, 16'h0);
        reset_n = 1'b1;
        tick;

        // Word read, no wait states
        start(1'b0, 16'o100000, 1'b1, 1'b0, 16'd0);
        tick;
        chk("rd_strobe", 16'({mrd, mwe}), 16'h4);
        chk("rd_maddr",  16'(maddr), 16'd0);
        chk("rd_sel",    16'(sel), 16'd1);
        tick;
        chk("rd_strobe_off", 16'({mrd, mwe, rply}), 16'h0);
        tick;
        chk("rd_rply_c3", 16'(rply), 16'd1);
        chk("rd_data",    rdata, 16'o123456);
        tick;
        chk("rd_hold",    rdata, 16'o123456);
        chk("rd_counts",  16'({n_rply[3:0], n_rd[3:0]}), 16'h11);
        endc;
        chk("rd_release", 16'({sel, rdata}), 16'h0);

        // Word write
        start(1'b0, 16'o100002, 1'b0, 1'b0, 16'o052525);
        tick;
        chk("wr_we",    16'({mrd, mwe}), 16'h3);
        chk("wr_maddr", 16'(maddr), 16'd1);
        chk("wr_wdata", mwd, 16'o052525);
        tick; tick;
        chk("wr_rply",  16'(rply), 16'd1);
        chk("wr_rdata", rdata, 16'h0);
        tick;
        endc;
        chk("wr_counts", 16'({n_rply[3:0], n_we[3:0], n_rd[3:0]}), 16'h110);

        // Byte write, odd then even
        start(1'b0, 16'o100005, 1'b0, 1'b1, 16'hAB00);
        tick;
        chk("wb_odd_we",    16'({mrd, mwe}), 16'h2);
        chk("wb_odd_maddr", 16'(maddr), 16'd2);
        tick; tick; tick;
        endc;
        start(1'b0, 16'o100004, 1'b0, 1'b1, 16'h00CD);
        tick;
        chk("wb_even_we",    16'({mrd, mwe}), 16'h1);
        chk("wb_even_maddr", 16'(maddr), 16'd2);
        tick; tick; tick;
        endc;
        chk("wb_even_rply", 16'(n_rply), 16'd1);

        // Window edges
        start(1'b0, 16'o103777, 1'b1, 1'b0, 16'd0);
        tick;
        chk("edge_maddr", 16'(maddr), 16'd1023);
        chk("edge_rd",    16'(mrd), 16'd1);
        tick; tick;
        chk("edge_rply",  16'(rply), 16'd1);
        chk("edge_data",  rdata, 16'hA63C);
        tick;
        endc;
        start(1'b0, 16'o104000, 1'b1, 1'b0, 16'd0);
        repeat (5) tick;
        endc;
        chk("oow_hi_quiet", 16'(n_rply + n_rd + n_we + n_sel), 16'd0);
        start(1'b0, 16'o077776, 1'b1, 1'b0, 16'd0);
        repeat (5) tick;
        endc;
        chk("oow_lo_quiet", 16'(n_rply + n_rd + n_we + n_sel), 16'd0);
        start(1'b0, 16'o100000, 1'b1, 1'b0, 16'd0);
        tick; tick; tick;
        chk("post_oow_rply", 16'(rply), 16'd1);
        tick;
        endc;

        // Four wait states: reply on ce cycle 7
        start(1'b1, 16'o100012, 1'b1, 1'b0, 16'd0);
        repeat (4) tick;
        chk("ws_no_rd_yet", 16'(n_rd), 16'd0);
        tick;
        chk("ws_rd_c5",  16'({mrd, maddr}), 16'h405);
        tick;
        chk("ws_no_early", 16'(n_rply), 16'd0);
        tick;
        chk("ws_rply_c7", 16'(rply), 16'd1);
        chk("ws_data",    rdata, 16'hA5C6);
        tick;
        endc;

        // Abort after two ce cycles in WAIT
        start(1'b1, 16'o100012, 1'b1, 1'b0, 16'd0);
        tick; tick;
        sync = 1'b0; din = 1'b0;
        tick;
        chk("ab_idle_sel", 16'(sel), 16'd0);
        repeat (6) tick;
        chk("ab_quiet", 16'(n_rply + n_rd), 16'd0);

        // Reset during CAPTURE
        start(1'b0, 16'o100000, 1'b1, 1'b0, 16'd0);
        tick; tick;
        reset_n = 1'b0;
        tick;
        chk("rstmid_ctl",   16'({rply, sel, mrd, mwe}), 16'h0);
        chk("rstmid_rdata", rdata, 16'h0);
        reset_n = 1'b1; sync = 1'b0; din = 1'b0; n_rply = 0;
        repeat (4) tick;
        chk("rstmid_no_rply", 16'(n_rply), 16'd0);

        // SYNC held across two cycles: one reply only
        start(1'b0, 16'o100000, 1'b1, 1'b0, 16'd0);
        repeat (4) tick;
        addr = 16'o100002;
        repeat (8) tick;
        chk("held_one_rply", 16'(n_rply), 16'd1);
        endc;

        // ce low for 3 cycles in REPLY stretches RPLY to 4 clk
        start(1'b0, 16'o100000, 1'b1, 1'b0, 16'd0);
        tick; tick; tick;
        chk("ce_rply_on", 16'(rply), 16'd1);
        ce = 1'b0;
        tick; tick; tick;
        ce = 1'b1;
        tick;
        chk("ce_stretch", 16'(n_rply), 16'd4);
        chk("ce_rply_off", 16'(rply), 16'd0);
        endc;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mpi_slave.md
# mpi_slave

Bus responder for the 1801VM1 CPU's SYNC/DIN/DOUT/WTBT/RPLY interface. It sits on the CPU side of the bus and decodes a fixed address window. On a match it runs one word or byte access against a synchronous RAM port, then answers the CPU with a one-cycle RPLY pulse. Out-of-window cycles get no reply, so other responders or the master's timeout handle them.

## Interface
- BASE, 16'o100000, byte address of window start; must be aligned to window size (2^(AW+1) bytes)
- AW, 10, RAM word-address width; window = 2^AW words
- WAIT_STATES, 0, extra ce-cycles inserted before the RAM access (0..15)

- clk  in  1  system clock; all logic on posedge
- reset_n  in  1  synchronous reset, active low
- ce  in  1  clock enable; state advances only when ce=1
- bus_addr  in  16  byte address from master; valid while SYNC=1
- bus_wdata  in  16  write data from master; valid while DOUT=1
- bus_rdata  out  16  read data to master; zero when not driving (OR-able)
- SYNC  in  1  bus cycle active
- DIN  in  1  read cycle
- DOUT  in  1  write cycle
- WTBT  in  1  byte access
- RPLY  out  1  reply, one ce-cycle pulse
- sel  out  1  this responder owns the current cycle
- mem_addr  out  AW  RAM word address
- mem_rd  out  1  RAM read strobe
- mem_we  out  2  RAM byte-lane write enables, {hi,lo}
- mem_wdata  out  16  RAM write data
- mem_rdata  in  16  RAM read data, valid one clk after mem_rd

## Operation
States: IDLE, WAIT, ACCESS, CAPTURE, REPLY, RELEASE. All transitions are qualified by ce.
- **IDLE**
  - Sample SYNC & (DIN xor DOUT).
  - If bus_addr is in [BASE, BASE+2^(AW+1)):
    - latch mem_addr = bus_addr[AW:1], dir = DOUT, byte = WTBT, odd = bus_addr[0], and wdata;
    - load wait counter = WAIT_STATES;
    - go to WAIT, or to ACCESS if WAIT_STATES=0.
  - Out of window: go to RELEASE, with no sel and no RPLY.
  - DIN and DOUT both high: protocol error; stay in IDLE, no response.
- **WAIT**: decrement the counter each ce cycle; go to ACCESS when it reaches 1.
- **ACCESS**: drive exactly one ce-cycle strobe:
  - read: mem_rd=1;
  - write word: mem_we=11;
  - write byte, even address: mem_we=01;
  - write byte, odd address: mem_we=10.
  - mem_wdata = latched wdata. For byte writes the master presents the byte in the lane selected by addr[0].
- **CAPTURE**:
  - read: bus_rdata register <= mem_rdata (full word; the master extracts the byte);
  - write: bus_rdata stays 0.
- **REPLY**: RPLY=1 for exactly one ce cycle; then go to RELEASE.
- **RELEASE**:
  - bus_rdata is held, RPLY=0.
  - Wait for SYNC=0, then clear bus_rdata and sel and return to IDLE.
  - The master must drop SYNC for at least 1 ce cycle between cycles. If SYNC stays high, no second reply is given.
- **Abort**: SYNC=0 in WAIT, ACCESS, CAPTURE or REPLY returns the block to IDLE next ce cycle.
  - An already-issued RAM strobe is not undone.
  - No RPLY is produced after the abort is seen.
- sel=1 from WAIT/ACCESS entry through the end of RELEASE, for in-window cycles only.

## Timing
- Reset (reset_n=0 at a posedge, regardless of ce):
  - state = IDLE;
  - RPLY=0, sel=0, bus_rdata=0, mem_rd=0, mem_we=00, mem_addr=0, mem_wdata=0;
  - wait counter = 0.
- Reset mid-access: any pending strobe is dropped on the same edge; no RPLY follows.
- ce=0 freezes all registers; strobes and RPLY stretch by the number of ce=0 cycles.
- Latency, counted from the first ce edge sampling SYNC high in IDLE to the RPLY-high cycle:
  - WAIT_STATES+3 ce cycles (IDLE→ACCESS→CAPTURE→REPLY, plus waits);
  - WAIT_STATES=0 gives 3.
- mem_rd and mem_we are never high together. The strobe is high for exactly one ce cycle per access.
- bus_rdata is valid from the cycle RPLY rises until SYNC falls.
- Address arithmetic:
  - mem_addr = bus_addr[AW:1]; the BASE bits are stripped by the alignment rule;
  - the last in-window byte address BASE+2^(AW+1)-1 maps to mem_addr = all ones;
  - BASE+2^(AW+1) is out of window.

## Test plan
- **Word read, WAIT_STATES=0:**
  - Stimulus: RAM word 0 = 16'o123456; SYNC=DIN=1, bus_addr=16'o100000.
  - Required: mem_rd for 1 cycle with mem_addr=0; RPLY pulses on the 3rd ce cycle; bus_rdata=16'o123456 until SYNC drops, then 0.
- **Word write:**
  - Stimulus: SYNC=DOUT=1, bus_addr=16'o100002, bus_wdata=16'o052525.
  - Required: mem_we=11, mem_addr=1, mem_wdata=16'o052525 for 1 cycle; single RPLY pulse; bus_rdata stays 0.
- **Byte writes:**
  - Stimulus: WTBT=1 to 16'o100005 (odd), then to 16'o100004 (even).
  - Required: mem_we=10 then mem_we=01, with mem_addr=2 both times.
- **Window edges:**
  - Stimulus: read 16'o103777, then 16'o104000 and 16'o077776.
  - Required: 16'o103777 gives mem_addr=1023 and a reply; the other two give no mem strobe, sel=0, and no RPLY; the responder returns to IDLE after SYNC drops.
- **Wait states and abort, WAIT_STATES=4:**
  - Stimulus: a normal read; then a read where SYNC drops after 2 ce cycles.
  - Required: normal read replies on ce cycle 7; the aborted read gives no mem_rd, no RPLY, and IDLE next cycle.
- **Reset during CAPTURE, and held SYNC:**
  - Stimulus: assert reset_n=0 during CAPTURE of a read; separately, hold SYNC high across two cycles with no gap.
  - Required: reset gives all outputs 0 and no RPLY on the next edge; held SYNC yields only one RPLY; ce held low for 3 cycles during REPLY stretches RPLY to 4 clk.
